cnn_top: RTL and testbench

Single-layer CNN inference engine. It fetches a 28×28 8-bit image from external DRAM and convolves it with one 3×3 signed kernel plus bias (zero padding 1). It then applies ReLU, requantisation and 2×2/stride-2 max-pooling, and writes the 14×14 pooled map back to DRAM packed eight pixels per 64-bit word. It is the top of the accelerator hierarchy; DRAM is external with a one-cycle read latency.

---
 rtl/cnn_top.sv | 193 +++++++++++++++++++
 tb/tb_cnn_top.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_top.sv
// cnn_top: single-layer CNN inference engine.
//
// Loads a 28x28 8-bit image (98 words of 8 pixels) from external DRAM,
// then computes a 3x3 signed convolution with bias and zero padding. Each
// result goes through ReLU, a right shift by SHIFT and saturation to 8 bits.
// A 2x2/stride-2 max-pool follows, and the 14x14 result is written back to
// DRAM, eight pooled pixels per 64-bit word.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   ifmap[63:0]    DRAM read data (one-cycle latency), pixel n in [8n+7:8n]
//   filter[71:0]   3x3 kernel, weight k=3i+j in [71-8k:64-8k], signed
//   bias[15:0]     signed bias at product scale
//   DRAMreadEn     read request
//   DRAMreadAddr   read word address
//   DRAMwriteEn    write strobe (one cycle per word)
//   DRAMwriteAddr  write word address; reaches 25 on completion
//   DRAMwriteData  write data, pooled pixel 8a+n in bits [8n+7:8n]
module cnn_top #(
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ifmap,
  input  logic [71:0] filter,
  input  logic [15:0] bias,
  output logic        DRAMreadEn,
  output logic [9:0]  DRAMreadAddr,
  output logic        DRAMwriteEn,
  output logic [9:0]  DRAMwriteAddr,
  output logic [63:0] DRAMwriteData
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  state_t             state;
  logic               rd_pend;        // a read was issued last cycle
  logic [6:0]         rd_pend_addr;   // its word address
  logic [63:0]        img_words [0:97];
  logic [3:0]         pool_row;
  logic [3:0]         pool_col;
  logic [7:0]         pix_cnt;        // pooled pixel index 0..196
  logic [63:0]        pack_buf;
  logic [63:0]        pack_next;
  logic [7:0]         patch [0:15];   // 4x4 input neighbourhood of one pooled pixel
  logic signed [20:0] wt [0:8];
  logic [7:0]         qv [0:3];
  logic [7:0]         max_a;
  logic [7:0]         max_b;
  logic [7:0]         pooled;
  logic               computing;
  logic               word_end;

  // Image buffer: the word addressed one cycle earlier arrives on ifmap now.
  always_ff @(posedge clk) begin
    if (rd_pend) img_words[rd_pend_addr] <= ifmap;
  end

  genvar gi;

  // Kernel weights, sign-extended to the accumulator width.
  generate
    for (gi = 0; gi < 9; gi++) begin : g_wt
      assign wt[gi] = 21'($signed(filter[71-8*gi -: 8]));
    end
  endgenerate

  // Fetch the 4x4 patch covering rows 2r-1..2r+2, cols 2c-1..2c+2.
  // Positions outside the image read as zero (padding).
  generate
    for (gi = 0; gi < 16; gi++) begin : g_patch
      logic signed [6:0] prow;
      logic signed [6:0] pcol;
      logic [9:0]        pidx;
      logic              in_rng;
      logic [7:0]        pix;
      always_comb begin
        prow   = 7'(2 * int'(pool_row) + gi / 4 - 1);
        pcol   = 7'(2 * int'(pool_col) + gi % 4 - 1);
        in_rng = (prow >= 7'sd0) && (prow <= 7'sd27) &&
                 (pcol >= 7'sd0) && (pcol <= 7'sd27);
        pidx   = 10'(28 * int'(prow) + int'(pcol));
        pix    = 8'd0;
        if (in_rng) pix = img_words[pidx[9:3]][{pidx[2:0], 3'b000} +: 8];
      end
      assign patch[gi] = pix;
    end
  endgenerate

  // Four convolution windows (dy,dx) evaluated in parallel, each with ReLU,
  // shift and saturation.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      logic signed [20:0] acc;
      logic signed [20:0] shifted;
      logic [7:0]         q;
      always_comb begin
        acc = 21'($signed(bias));
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            acc = acc + $signed({13'd0, patch[4'((gi / 2 + i) * 4 + gi % 2 + j)]})
                        * wt[4'(3 * i + j)];
          end
        end
        shifted = acc >>> SHIFT;
        if (acc < 21'sd0)            q = 8'd0;
        else if (shifted > 21'sd255) q = 8'd255;
        else                         q = shifted[7:0];
      end
      assign qv[gi] = q;
    end
  endgenerate

  always_comb begin
    max_a  = (qv[0] > qv[1]) ? qv[0] : qv[1];
    max_b  = (qv[2] > qv[3]) ? qv[2] : qv[3];
    pooled = (max_a > max_b) ? max_a : max_b;
  end

  // Current pack word with this cycle's pooled pixel inserted.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pack
      assign pack_next[8*gi +: 8] = (pix_cnt[2:0] == 3'(gi)) ? pooled : pack_buf[8*gi +: 8];
    end
  endgenerate

  assign computing = (pix_cnt != 8'd196);
  assign word_end  = (pix_cnt[2:0] == 3'd7) || (pix_cnt == 8'd195);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      DRAMreadEn    <= 1'b0;
      DRAMreadAddr  <= 10'd0;
      DRAMwriteEn   <= 1'b0;
      DRAMwriteAddr <= 10'd0;
      DRAMwriteData <= 64'd0;
      rd_pend       <= 1'b0;
      rd_pend_addr  <= 7'd0;
      pix_cnt       <= 8'd0;
      pool_row      <= 4'd0;
      pool_col      <= 4'd0;
      pack_buf      <= 64'd0;
    end else begin
      DRAMwriteEn  <= 1'b0;
      rd_pend      <= DRAMreadEn;
      rd_pend_addr <= DRAMreadAddr[6:0];
      case (state)
        IDLE: begin
          state        <= LOAD;
          DRAMreadEn   <= 1'b1;
          DRAMreadAddr <= 10'd0;
        end
        LOAD: begin
          if (DRAMreadEn) begin
            if (DRAMreadAddr == 10'd97) DRAMreadEn   <= 1'b0;
            else                        DRAMreadAddr <= DRAMreadAddr + 10'd1;
          end
          // Word 97 is being captured on this edge.
          if (rd_pend && rd_pend_addr == 7'd97) state <= COMPUTE;
        end
        COMPUTE: begin
          if (computing) begin
            pix_cnt <= pix_cnt + 8'd1;
            if (pool_col == 4'd13) begin
              pool_col <= 4'd0;
              pool_row <= pool_row + 4'd1;
            end else begin
              pool_col <= pool_col + 4'd1;
            end
            if (word_end) begin
              DRAMwriteEn   <= 1'b1;
              DRAMwriteData <= pack_next;
              pack_buf      <= 64'd0;   // keeps unused bytes of the last word zero
            end else begin
              pack_buf <= pack_next;
            end
          end
          // Stay in COMPUTE until the final write has been presented.
          if (DRAMwriteEn) begin
            DRAMwriteAddr <= DRAMwriteAddr + 10'd1;
            if (DRAMwriteAddr == 10'd24) state <= DONE;
          end
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_top.sv
// tb_cnn_top: scoreboard bench for cnn_top. A DRAM model serves reads with
// one-cycle latency. Each run pushes the 25 expected write words, computed
// by a plain-arithmetic reference model, into a queue. A monitor pops and
// compares them as the DUT writes.
module tb_cnn_top;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] ifmap;
  logic [71:0] filter = '0;
  logic [15:0] bias = '0;
  logic        DRAMreadEn;
  logic [9:0]  DRAMreadAddr;
  logic        DRAMwriteEn;
  logic [9:0]  DRAMwriteAddr;
  logic [63:0] DRAMwriteData;

  cnn_top #(.SHIFT(4)) dut (
    .clk(clk), .rst(rst), .ifmap(ifmap), .filter(filter), .bias(bias),
    .DRAMreadEn(DRAMreadEn), .DRAMreadAddr(DRAMreadAddr),
    .DRAMwriteEn(DRAMwriteEn), .DRAMwriteAddr(DRAMwriteAddr),
    .DRAMwriteData(DRAMwriteData)
  );

  always #5 clk = ~clk;

  // External DRAM: one-cycle read latency; junk on the bus otherwise.
  logic [63:0] mem [0:97];
  always @(posedge clk) begin
    if (DRAMreadEn && DRAMreadAddr < 10'd98) ifmap <= mem[DRAMreadAddr];
    else ifmap <= {$urandom, $urandom};
  end

  typedef struct {
    int          addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  wr_count = 0;
  int  rd_next = 0;
  int  rd_run = 0;

  int  img [784];
  int  wts [9];
  int  bias_v;

  // Monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if (DRAMreadEn || DRAMwriteEn || DRAMreadAddr != 0 || DRAMwriteAddr != 0 || DRAMwriteData != 0) begin
        n_err++;
        $display("FAIL reset_outputs: got ren=%0b raddr=%0d wen=%0b waddr=%0d wdata=%h, required all 0",
                 DRAMreadEn, DRAMreadAddr, DRAMwriteEn, DRAMwriteAddr, DRAMwriteData);
      end
      rd_next  = 0;
      rd_run   = 0;
      wr_count = 0;
    end else begin
      if (DRAMreadEn || DRAMwriteEn) begin
        n_cmp++;
        if (DRAMreadEn && DRAMwriteEn) begin
          n_err++;
          $display("FAIL rw_overlap: read and write both active at raddr=%0d waddr=%0d", DRAMreadAddr, DRAMwriteAddr);
        end
      end
      if (DRAMreadEn) begin
        n_cmp++;
        if (int'(DRAMreadAddr) != rd_next) begin
          n_err++;
          $display("FAIL read_addr: got %0d, required %0d", DRAMreadAddr, rd_next);
        end
        rd_next++;
        rd_run++;
      end else if (rd_run != 0) begin
        n_cmp++;
        if (rd_run != 98) begin
          n_err++;
          $display("FAIL read_burst_len: got %0d cycles, required 98", rd_run);
        end
        rd_run = 0;
      end
      if (DRAMwriteEn) begin
        wr_count++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", DRAMwriteAddr, DRAMwriteData);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (int'(DRAMwriteAddr) != e.addr || DRAMwriteData !== e.data) begin
            n_err++;
            $display("FAIL write_word: got addr=%0d data=%h, required addr=%0d data=%h",
                     DRAMwriteAddr, DRAMwriteData, e.addr, e.data);
          end else begin
            $display("write addr=%0d data=%h ok", DRAMwriteAddr, DRAMwriteData);
          end
        end
      end
    end
  end

  // Reference model: convolution, ReLU, shift, saturate and pool, computed
  // straight from the image array. Loads DRAM and pushes expected words.
  task automatic build_and_push();
    int pooled [196];
    logic [63:0] w;
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < 14; c++) begin
        int mx;
        mx = 0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            int s;
            int q;
            s = bias_v;
            for (int i = 0; i < 3; i++) begin
              for (int j = 0; j < 3; j++) begin
                int yy;
                int xx;
                yy = 2 * r + dy + i - 1;
                xx = 2 * c + dx + j - 1;
                if (yy >= 0 && yy < 28 && xx >= 0 && xx < 28)
                  s += wts[3 * i + j] * img[28 * yy + xx];
              end
            end
            q = (s < 0) ? 0 : s / 16;
            if (q > 255) q = 255;
            if (q > mx) mx = q;
          end
        end
        pooled[14 * r + c] = mx;
      end
    end
    for (int a = 0; a < 25; a++) begin
      wr_t e;
      w = '0;
      for (int n = 0; n < 8; n++) begin
        if (8 * a + n < 196) w[8 * n +: 8] = 8'(pooled[8 * a + n]);
      end
      e.addr = a;
      e.data = w;
      exp_q.push_back(e);
    end
    for (int a = 0; a < 98; a++) begin
      w = '0;
      for (int n = 0; n < 8; n++) w[8 * n +: 8] = 8'(img[8 * a + n]);
      mem[a] = w;
    end
    for (int k = 0; k < 9; k++) filter[71 - 8 * k -: 8] = 8'(wts[k]);
    bias = 16'(bias_v);
  endtask

  task automatic run_test(input string name, input bit mid_reset);
    int cycles;
    build_and_push();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    if (mid_reset) begin
      repeat (40) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
    end
    cycles = 0;
    while (DRAMwriteAddr != 10'd25 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    n_cmp++;
    if (cycles >= 2000) begin
      n_err++;
      $display("FAIL %s timeout: DRAMwriteAddr=%0d after %0d cycles, required 25", name, DRAMwriteAddr, cycles);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (DRAMwriteEn !== 1'b0 || DRAMwriteAddr !== 10'd25) begin
      n_err++;
      $display("FAIL %s done_state: got wen=%0b waddr=%0d, required wen=0 waddr=25", name, DRAMwriteEn, DRAMwriteAddr);
    end
    n_cmp++;
    if (wr_count != 25 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s write_count: got %0d writes with %0d expected words left, required 25 and 0",
               name, wr_count, exp_q.size());
    end
    exp_q.delete();
    $display("run %s: cycles=%0d writes=%0d", name, cycles, wr_count);
  endtask

  task automatic set_base_filter();
    wts = '{-7, -19, 26, 13, -15, -12, 16, 10, -15};
    bias_v = 459;
  endtask

  task automatic random_filter();
    for (int k = 0; k < 9; k++) wts[k] = int'($urandom_range(255)) - 128;
    bias_v = int'($urandom_range(6000)) - 2000;
  endtask

  initial begin
    // All-zero image: every pooled pixel 459>>4 = 28.
    set_base_filter();
    for (int p = 0; p < 784; p++) img[p] = 0;
    run_test("zero_image", 1'b0);

    // Single bright pixel at (0,0).
    img[0] = 255;
    run_test("corner_pixel", 1'b0);

    // All-255 image: interior windows go negative and clip to 0.
    for (int p = 0; p < 784; p++) img[p] = 255;
    run_test("all_255", 1'b0);

    // Saturation: large positive kernel.
    for (int k = 0; k < 9; k++) wts[k] = 127;
    bias_v = 0;
    run_test("saturate", 1'b0);

    // Random images and kernels.
    for (int t = 0; t < 3; t++) begin
      random_filter();
      for (int p = 0; p < 784; p++) img[p] = int'($urandom_range(255));
      run_test($sformatf("random_%0d", t), 1'b0);
    end

    // Sparse random image with base kernel, uninterrupted then with a
    // one-cycle reset in the middle of LOAD; both must match the model.
    set_base_filter();
    for (int p = 0; p < 784; p++) img[p] = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : 0;
    run_test("sparse", 1'b0);
    run_test("mid_load_reset", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
